// File: rtl/simd_booth_pkg.sv
// Shared definitions for the SIMD radix-2 Booth multiplier: lane modes,
// sequencer state encoding and per-mode iteration counts.
package simd_booth_pkg;

  localparam int CNT_W_DEF = 5;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_1X16 = 2'b00;
  localparam mode_t MODE_2X8  = 2'b01;
  localparam mode_t MODE_4X4  = 2'b10;
  localparam mode_t MODE_RSVD = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // One radix-2 Booth step per multiplier bit of a lane.
  function automatic logic [CNT_W_DEF-1:0] iter_count(input mode_t mode);
    case (mode)
      MODE_1X16: iter_count = 5'd16;
      MODE_2X8:  iter_count = 5'd8;
      MODE_4X4:  iter_count = 5'd4;
      default:   iter_count = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/simd_booth_sequencer.sv
// Control FSM sequencing load / add / shift steps of the SIMD Booth datapath.
// Result valid 2N+2 cycles after command; holds DONE until out_ready; abort wins.
module simd_booth_sequencer
  import simd_booth_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode_in,
  input  logic             abort,
  output logic [1:0]       mode_q,
  output logic             load_en,
  output logic             add_en,
  output logic             shift_en,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             busy,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);

  if ((2 ** CNT_W) <= 16) begin : g_cnt_w_check
    $error("CNT_W too small to hold an iteration count of 16");
  end

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  mode_t            mode_nxt;
  logic             err_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = iter_cnt;
    mode_nxt  = mode_q;
    err_nxt   = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            // Reserved mode is consumed and flagged but never started.
            if (mode_in == MODE_RSVD) begin
              err_nxt = 1'b1;
            end else begin
              mode_nxt  = mode_in;
              cnt_nxt   = CNT_W'(iter_count(mode_in));
              state_nxt = ST_LOAD;
            end
          end
        end
        ST_LOAD:  state_nxt = ST_ADD;
        ST_ADD:   state_nxt = ST_SHIFT;
        ST_SHIFT: begin
          if (iter_cnt > CNT_W'(1)) begin
            cnt_nxt   = iter_cnt - CNT_W'(1);
            state_nxt = ST_ADD;
          end else begin
            cnt_nxt   = '0;
            state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      iter_cnt <= '0;
      mode_q   <= MODE_1X16;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      iter_cnt <= cnt_nxt;
      mode_q   <= mode_nxt;
      err      <= err_nxt;
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign load_en   = (state == ST_LOAD);
  assign add_en    = (state == ST_ADD);
  assign shift_en  = (state == ST_SHIFT);
  assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_simd_booth_sequencer.sv
// Self-checking bench for simd_booth_sequencer; per-operation expectations
// come from the lane-mode rules (N = 16 >> mode, result after 2N+2 cycles).
module tb_simd_booth_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] mode_in;
  logic       abort;
  logic [1:0] mode_q;
  logic       load_en;
  logic       add_en;
  logic       shift_en;
  logic [4:0] iter_cnt;
  logic       busy;
  logic       err;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int fails  = 0;

  simd_booth_sequencer #(.CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode_in(mode_in), .abort(abort), .mode_q(mode_q), .load_en(load_en),
    .add_en(add_en), .shift_en(shift_en), .iter_cnt(iter_cnt), .busy(busy),
    .err(err), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_iters(input logic [1:0] m);
    return 16 >> m;
  endfunction

  function automatic int model_latency(input logic [1:0] m);
    return 2 * model_iters(m) + 2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one command from IDLE and observes it up to out_valid.
  // lat counts edges from the accepting edge (inclusive) until out_valid.
  task automatic drive_op(input logic [1:0] m, output int lat, output int nl,
                          output int na, output int ns, output int glitch);
    int cyc;
    lat = -1; nl = 0; na = 0; ns = 0; glitch = 0; cyc = 0;
    in_valid = 1'b1;
    mode_in  = m;
    while (lat < 0 && cyc < 200) begin
      step();
      cyc++;
      in_valid = 1'b0;
      nl += int'(load_en);
      na += int'(add_en);
      ns += int'(shift_en);
      if (int'(load_en) + int'(add_en) + int'(shift_en) > 1) glitch++;
      if (busy === in_ready) glitch++;
      if (busy && mode_q !== m) glitch++;
      if (out_valid) lat = cyc;
    end
  endtask

  // Holds out_ready low for 'hold' cycles then completes the handshake.
  task automatic drain(input int hold, output int held_bad, output logic idle_after);
    held_bad = 0;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (out_valid !== 1'b1 || in_ready !== 1'b0) held_bad++;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    idle_after = in_ready && !busy && !out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; mode_in = 2'b00; abort = 1'b0; out_ready = 1'b0;
    #12;
    checks++;
    if ({load_en, add_en, shift_en, busy, err, out_valid, mode_q, iter_cnt} !== 12'd0 ||
        in_ready !== 1'b1)
      begin fails++; $display("FAIL reset_state: got ld=%b ad=%b sh=%b busy=%b err=%b ov=%b mode=%b cnt=%0d rdy=%b, want all 0 and rdy=1",
        load_en, add_en, shift_en, busy, err, out_valid, mode_q, iter_cnt, in_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mode00();
    int lat, nl, na, ns, g, hb; logic idle;
    drive_op(2'b00, lat, nl, na, ns, g);
    checks++;
    if (lat !== model_latency(2'b00)) begin fails++; $display("FAIL m00_latency: got %0d want %0d", lat, model_latency(2'b00)); end
    checks++;
    if (nl !== 1 || na !== 16 || ns !== 16) begin fails++; $display("FAIL m00_pulses: got load=%0d add=%0d shift=%0d want 1/16/16", nl, na, ns); end
    checks++;
    if (g !== 0 || iter_cnt !== 5'd0) begin fails++; $display("FAIL m00_invariants: got %0d violations cnt=%0d want 0/0", g, iter_cnt); end
    drain(3, hb, idle);
    checks++;
    if (hb !== 0) begin fails++; $display("FAIL m00_hold: got %0d drops of out_valid want 0", hb); end
    checks++;
    if (idle !== 1'b1) begin fails++; $display("FAIL m00_idle_after: got %b want 1", idle); end
  endtask

  task automatic test_modes();
    int lat, nl, na, ns, g, hb; logic idle;
    for (int k = 1; k <= 2; k++) begin
      logic [1:0] m;
      m = 2'(k);
      drive_op(m, lat, nl, na, ns, g);
      checks++;
      if (lat !== model_latency(m) || ns !== model_iters(m) || nl !== 1 || g !== 0)
        begin fails++; $display("FAIL mode%0d_op: got lat=%0d shifts=%0d loads=%0d viol=%0d want %0d/%0d/1/0",
          k, lat, ns, nl, g, model_latency(m), model_iters(m)); end
      drain(0, hb, idle);
      checks++;
      if (idle !== 1'b1 || mode_q !== m) begin fails++; $display("FAIL mode%0d_end: got idle=%b mode_q=%b want 1/%b", k, idle, mode_q, m); end
    end
  endtask

  task automatic test_reserved();
    int lat, nl, na, ns, g, hb; logic idle;
    logic [1:0] prev_mode;
    prev_mode = mode_q;
    in_valid = 1'b1; mode_in = 2'b11;
    step();
    in_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || load_en !== 1'b0 || in_ready !== 1'b1 || mode_q !== prev_mode)
      begin fails++; $display("FAIL rsvd_err: got err=%b busy=%b load=%b rdy=%b mode=%b want 1/0/0/1/%b",
        err, busy, load_en, in_ready, mode_q, prev_mode); end
    step();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rsvd_pulse: got err=%b busy=%b want 0/0", err, busy); end
    drive_op(2'b10, lat, nl, na, ns, g);
    checks++;
    if (lat !== model_latency(2'b10) || ns !== 4 || g !== 0) begin fails++; $display("FAIL rsvd_next: got lat=%0d shifts=%0d viol=%0d want 10/4/0", lat, ns, g); end
    drain(1, hb, idle);
  endtask

  task automatic test_abort();
    int adds, cyc, seen_ov, lat, nl, na, ns, g;
    adds = 0; cyc = 0;
    in_valid = 1'b1; mode_in = 2'b00;
    while (adds < 5 && cyc < 200) begin
      step(); cyc++;
      in_valid = 1'b0;
      adds += int'(add_en);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || iter_cnt !== 5'd0 || out_valid !== 1'b0 || err !== 1'b0)
      begin fails++; $display("FAIL abort_add: got busy=%b rdy=%b cnt=%0d ov=%b err=%b (adds=%0d) want 0/1/0/0/0",
        busy, in_ready, iter_cnt, out_valid, err, adds); end
    seen_ov = 0;
    for (int i = 0; i < 40; i++) begin step(); seen_ov += int'(out_valid | busy); end
    checks++;
    if (seen_ov !== 0) begin fails++; $display("FAIL abort_quiet: got %0d active cycles want 0", seen_ov); end
    drive_op(2'b10, lat, nl, na, ns, g);
    out_ready = 1'b1; abort = 1'b1;
    step();
    out_ready = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || iter_cnt !== 5'd0 || err !== 1'b0 || lat !== 10)
      begin fails++; $display("FAIL abort_done: got busy=%b ov=%b cnt=%0d err=%b lat=%0d want 0/0/0/0/10", busy, out_valid, iter_cnt, err, lat); end
    // Abort in IDLE drops the offered command.
    in_valid = 1'b1; mode_in = 2'b01; abort = 1'b1;
    step();
    in_valid = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || mode_q !== 2'b10)
      begin fails++; $display("FAIL abort_idle: got busy=%b rdy=%b mode=%b want 0/1/10", busy, in_ready, mode_q); end
  endtask

  task automatic test_reset_mid();
    int cyc, lat, nl, na, ns, g, hb; logic idle;
    cyc = 0;
    in_valid = 1'b1; mode_in = 2'b00;
    step();
    in_valid = 1'b0;
    while (!(shift_en && iter_cnt == 5'd3) && cyc < 200) begin step(); cyc++; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({load_en, add_en, shift_en, busy, err, out_valid, mode_q, iter_cnt} !== 12'd0 || cyc >= 200)
      begin fails++; $display("FAIL reset_mid: got ld=%b ad=%b sh=%b busy=%b ov=%b cnt=%0d cyc=%0d want all 0",
        load_en, add_en, shift_en, busy, out_valid, iter_cnt, cyc); end
    #2;
    rst_n = 1'b1;
    step();
    drive_op(2'b01, lat, nl, na, ns, g);
    checks++;
    if (lat !== 18 || ns !== 8 || g !== 0) begin fails++; $display("FAIL reset_recover: got lat=%0d shifts=%0d viol=%0d want 18/8/0", lat, ns, g); end
    drain(0, hb, idle);
  endtask

  task automatic test_back_to_back();
    int cyc, lat, bad;
    cyc = 0; bad = 0; lat = -1;
    in_valid = 1'b1; mode_in = 2'b01;
    step(); cyc++;
    mode_in = 2'b10;
    while (!out_valid && cyc < 200) begin step(); cyc++; end
    checks++;
    if (cyc !== 18 || mode_q !== 2'b01) begin fails++; $display("FAIL b2b_first: got lat=%0d mode=%b want 18/01", cyc, mode_q); end
    for (int i = 0; i < 2; i++) begin
      step();
      if (!out_valid || in_ready || load_en) bad++;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (bad !== 0 || in_ready !== 1'b1 || load_en !== 1'b0)
      begin fails++; $display("FAIL b2b_gap: got early=%0d rdy=%b load=%b want 0/1/0", bad, in_ready, load_en); end
    cyc = 0;
    while (lat < 0 && cyc < 200) begin
      step(); cyc++;
      in_valid = 1'b0;
      if (cyc == 1 && (load_en !== 1'b1 || mode_q !== 2'b10)) bad++;
      if (out_valid) lat = cyc;
    end
    checks++;
    if (lat !== model_latency(2'b10) || bad !== 0)
      begin fails++; $display("FAIL b2b_second: got lat=%0d bad=%0d want %0d/0", lat, bad, model_latency(2'b10)); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int lat, nl, na, ns, g, hb; logic idle;
    for (int r = 0; r < 8; r++) begin
      logic [1:0] m;
      int hold;
      m = 2'($urandom_range(0, 2));
      hold = int'($urandom_range(0, 3));
      drive_op(m, lat, nl, na, ns, g);
      checks++;
      if (lat !== model_latency(m) || nl !== 1 || na !== model_iters(m) || ns !== model_iters(m) || g !== 0)
        begin fails++; $display("FAIL rand%0d_m%0d: got lat=%0d l/a/s=%0d/%0d/%0d viol=%0d want %0d 1/%0d/%0d 0",
          r, m, lat, nl, na, ns, g, model_latency(m), model_iters(m), model_iters(m)); end
      drain(hold, hb, idle);
      checks++;
      if (hb !== 0 || idle !== 1'b1) begin fails++; $display("FAIL rand%0d_drain: got drops=%0d idle=%b want 0/1", r, hb, idle); end
    end
  endtask

  initial begin
    test_reset();
    test_mode00();
    test_modes();
    test_reserved();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
